pll_reset_seq: RTL and testbench

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

---
 rtl/pll_reset_seq.sv | 175 +++++++++++++++++
 tb/tb_pll_reset_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_seq.sv
// PLL bring-up sequencer: resets the PLL, waits for a stable lock, then releases
// downstream reset domains one at a time; retries on lock timeout, faults after MAX_RETRIES.
module pll_reset_seq #(
    parameter int unsigned NUM_DOMAINS         = 2,
    parameter int unsigned RST_HOLD_CYCLES     = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned STAGGER_CYCLES      = 8
) (
    input  logic                   clk_in,
    input  logic                   reset_n,
    input  logic                   pll_locked,
    input  logic                   sw_relock,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   ready,
    output logic                   fault,
    output logic                   lock_lost,
    output logic [3:0]             retry_count
);

    localparam int unsigned MAX_AB  = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ?
                                      RST_HOLD_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MAX_CD  = (LOCK_TIMEOUT_CYCLES > STAGGER_CYCLES) ?
                                      LOCK_TIMEOUT_CYCLES : STAGGER_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [1:0]             sync_q;
    logic                   lock_s;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic [3:0]             retry_q, retry_d, retry_inc;
    logic                   lost_q, lost_d;
    logic                   pll_rst_q, pll_rst_d;
    logic                   ready_q, ready_d;
    logic                   fault_q, fault_d;

    assign lock_s = sync_q[1];

    // Next state, counters and the registered-output values for the next cycle
    always_comb begin
        state_d   = state_q;
        cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        cnt_d     = cnt_inc;
        retry_inc = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
        retry_d   = retry_q;
        lost_d    = lost_q;
        dom_d     = '0;

        if (sw_relock) begin
            state_d = S_RESET_PLL;
            cnt_d   = '0;
            retry_d = '0;
            lost_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_RESET_PLL: begin
                    if (cnt_q == CNT_W'(RST_HOLD_CYCLES - 1)) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = S_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        cnt_d   = '0;
                        retry_d = retry_inc;
                        state_d = (retry_inc == 4'(MAX_RETRIES)) ? S_FAULT : S_RESET_PLL;
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                        state_d = S_RELEASE;
                        cnt_d   = '0;
                    end
                end
                S_RELEASE: begin
                    if (!lock_s) begin
                        state_d = S_RESET_PLL;
                        cnt_d   = '0;
                        lost_d  = 1'b1;
                    end else if (cnt_q == CNT_W'(STAGGER_CYCLES - 1)) begin
                        cnt_d = '0;
                        if (&dom_q) begin
                            state_d = S_RUN;
                            retry_d = '0;
                        end
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_d = S_RESET_PLL;
                        cnt_d   = '0;
                        lost_d  = 1'b1;
                    end
                end
                S_FAULT: begin
                    cnt_d = cnt_q;
                end
                default: begin
                    state_d = S_RESET_PLL;
                    cnt_d   = '0;
                end
            endcase
        end

        // Domain mask grows by one bit every STAGGER_CYCLES while releasing
        unique case (state_d)
            S_RELEASE: begin
                if (state_q != S_RELEASE) begin
                    dom_d = NUM_DOMAINS'(1);
                end else if (cnt_q == CNT_W'(STAGGER_CYCLES - 1)) begin
                    dom_d = NUM_DOMAINS'({dom_q, 1'b1});
                end else begin
                    dom_d = dom_q;
                end
            end
            S_RUN:   dom_d = '1;
            default: dom_d = '0;
        endcase

        pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAULT);
        ready_d   = (state_d == S_RUN);
        fault_d   = (state_d == S_FAULT);
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state_q   <= S_RESET_PLL;
            cnt_q     <= '0;
            sync_q    <= '0;
            dom_q     <= '0;
            retry_q   <= '0;
            lost_q    <= 1'b0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync_q    <= {sync_q[0], pll_locked};
            dom_q     <= dom_d;
            retry_q   <= retry_d;
            lost_q    <= lost_d;
            pll_rst_q <= pll_rst_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    assign pll_rst      = pll_rst_q;
    assign domain_rst_n = dom_q;
    assign ready        = ready_q;
    assign fault        = fault_q;
    assign lock_lost    = lost_q;
    assign retry_count  = retry_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: timeline reference model checked every cycle, plus
// directed bring-up, glitch, timeout, loss-of-lock and mid-release reset scenarios.
module tb_pll_reset_seq;

    localparam int ND   = 3;
    localparam int HOLD = 4;
    localparam int STB  = 8;
    localparam int TO   = 32;
    localparam int MR   = 2;
    localparam int SG   = 2;

    localparam int P_RP    = 0;
    localparam int P_WAIT  = 1;
    localparam int P_STB   = 2;
    localparam int P_REL   = 3;
    localparam int P_RUN   = 4;
    localparam int P_FAULT = 5;

    logic          clk_in = 1'b0;
    logic          reset_n;
    logic          pll_locked;
    logic          sw_relock;
    logic          pll_rst;
    logic [ND-1:0] domain_rst_n;
    logic          ready;
    logic          fault;
    logic          lock_lost;
    logic [3:0]    retry_count;

    always #5 clk_in = ~clk_in;

    pll_reset_seq #(
        .NUM_DOMAINS(ND), .RST_HOLD_CYCLES(HOLD), .LOCK_STABLE_CYCLES(STB),
        .LOCK_TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR), .STAGGER_CYCLES(SG)
    ) dut (
        .clk_in(clk_in), .reset_n(reset_n), .pll_locked(pll_locked), .sw_relock(sw_relock),
        .pll_rst(pll_rst), .domain_rst_n(domain_rst_n), .ready(ready), .fault(fault),
        .lock_lost(lock_lost), .retry_count(retry_count)
    );

    int total  = 0;
    int passed = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    int m_ph    = P_RP;
    int m_t     = 0;
    int m_retry = 0;
    bit m_lost  = 1'b0;
    bit m_l1    = 1'b0;
    bit m_l2    = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    // Released domains follow elapsed time in the release phase
    function automatic int m_dom();
        int n;
        if (m_ph == P_RUN) return (1 << ND) - 1;
        if (m_ph != P_REL) return 0;
        n = m_t / SG + 1;
        if (n > ND) n = ND;
        return (1 << n) - 1;
    endfunction

    task automatic model_step();
        bit ls;
        if (!reset_n) begin
            m_ph = P_RP; m_t = 0; m_retry = 0; m_lost = 1'b0;
            m_l1 = 1'b0; m_l2 = 1'b0; cyc = 0;
            return;
        end
        cyc++;
        ls   = m_l2;
        m_l2 = m_l1;
        m_l1 = pll_locked;
        if (sw_relock) begin
            m_ph = P_RP; m_t = 0; m_retry = 0; m_lost = 1'b0;
            return;
        end
        case (m_ph)
            P_RP: begin
                m_t++;
                if (m_t == HOLD) begin m_ph = P_WAIT; m_t = 0; end
            end
            P_WAIT: begin
                if (ls) begin
                    m_ph = P_STB; m_t = 0;
                end else begin
                    m_t++;
                    if (m_t == TO) begin
                        if (m_retry < 15) m_retry++;
                        m_ph = (m_retry == MR) ? P_FAULT : P_RP;
                        m_t  = 0;
                    end
                end
            end
            P_STB: begin
                if (!ls) begin
                    m_ph = P_WAIT; m_t = 0;
                end else begin
                    m_t++;
                    if (m_t == STB) begin m_ph = P_REL; m_t = 0; end
                end
            end
            P_REL: begin
                if (!ls) begin
                    m_ph = P_RP; m_t = 0; m_lost = 1'b1;
                end else begin
                    m_t++;
                    if (m_t == ND * SG) begin m_ph = P_RUN; m_retry = 0; end
                end
            end
            P_RUN: begin
                if (!ls) begin m_ph = P_RP; m_t = 0; m_lost = 1'b1; end
            end
            default: ;
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clk_in);
            model_step();
            chk_en = 1'b1;
        end
    end

    // Cycle-by-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk_in);
            if (chk_en) begin
                check("pll_rst", int'(pll_rst), int'(m_ph == P_RP || m_ph == P_FAULT));
                check("domain_rst_n", int'(domain_rst_n), m_dom());
                check("ready", int'(ready), int'(m_ph == P_RUN));
                check("fault", int'(fault), int'(m_ph == P_FAULT));
                check("lock_lost", int'(lock_lost), int'(m_lost));
                check("retry_count", int'(retry_count), m_retry);
            end
        end
    end

    function automatic bit cond(input int sel);
        case (sel)
            0: return !pll_rst;
            1: return domain_rst_n[0];
            2: return domain_rst_n[1];
            3: return domain_rst_n[2];
            4: return ready;
            5: return retry_count == 4'd1;
            6: return fault;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget && at < 0; i++) begin
            @(negedge clk_in);
            if (cond(sel)) at = cyc;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pll_rst"}, int'(pll_rst), 1);
        check({tag, "_dom"}, int'(domain_rst_n), 0);
        check({tag, "_ready"}, int'(ready), 0);
        check({tag, "_fault"}, int'(fault), 0);
        check({tag, "_lost"}, int'(lock_lost), 0);
        check({tag, "_retry"}, int'(retry_count), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int at;
        int r;
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        sw_relock  = 1'b0;
        repeat (3) @(negedge clk_in);
        check_reset_values("por");

        // Clean bring-up with lock present from the start
        pll_locked = 1'b1;
        reset_n    = 1'b1;
        wait_for(0, 50, at); check("bringup_pll_rst_low_cyc", at, 4);
        wait_for(1, 50, at); check("bringup_dom0_cyc", at, 13);
        wait_for(2, 50, at); check("bringup_dom1_cyc", at, 15);
        wait_for(3, 50, at); check("bringup_dom2_cyc", at, 17);
        wait_for(4, 50, at); check("bringup_ready_cyc", at, 19);
        check("bringup_retry", int'(retry_count), 0);

        // Loss of lock in RUN
        repeat (3) @(negedge clk_in);
        pll_locked = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        check("loss_ready_still_high", int'(ready), 1);
        @(negedge clk_in);
        check("loss_dom", int'(domain_rst_n), 0);
        check("loss_ready", int'(ready), 0);
        check("loss_lost", int'(lock_lost), 1);
        check("loss_pll_rst", int'(pll_rst), 1);
        pll_locked = 1'b1;
        wait_for(4, 100, at);
        check("relock_ready_seen", int'(at > 0), 1);
        check("relock_lost_sticky", int'(lock_lost), 1);

        // Software relock then a one-cycle lock glitch in STABLE
        @(negedge clk_in);
        sw_relock = 1'b1;
        @(negedge clk_in);
        sw_relock = 1'b0;
        r = cyc;
        check("relock_clears_lost", int'(lock_lost), 0);
        check("relock_pll_rst", int'(pll_rst), 1);
        repeat (8) @(negedge clk_in);
        pll_locked = 1'b0;
        @(negedge clk_in);
        pll_locked = 1'b1;
        wait_for(1, 60, at);
        check("glitch_dom0_delay", at - r, 20);
        wait_for(4, 60, at);
        check("glitch_ready_seen", int'(at > 0), 1);

        // Lock never arrives: one retry, then FAULT, then software recovery
        @(negedge clk_in);
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        @(negedge clk_in);
        reset_n = 1'b1;
        wait_for(5, 100, at); check("timeout_retry1_cyc", at, 36);
        wait_for(6, 100, at); check("timeout_fault_cyc", at, 72);
        check("fault_pll_rst", int'(pll_rst), 1);
        repeat (5) @(negedge clk_in);
        check("fault_held", int'(fault), 1);
        sw_relock = 1'b1;
        @(negedge clk_in);
        sw_relock = 1'b0;
        check("fault_exit_retry", int'(retry_count), 0);
        check("fault_exit_fault", int'(fault), 0);
        check("fault_exit_pll_rst", int'(pll_rst), 1);

        // Reset in the middle of the release stagger
        pll_locked = 1'b1;
        wait_for(1, 100, at);
        check("midrel_dom0_seen", int'(at > 0), 1);
        reset_n = 1'b0;
        @(negedge clk_in);
        check_reset_values("midrel");
        reset_n = 1'b1;

        // Randomised episodes, checked by the per-cycle model
        for (int ep = 0; ep < 40; ep++) begin
            int mode;
            int len;
            mode = $urandom_range(0, 3);
            len  = $urandom_range(30, 200);
            for (int c = 0; c < len; c++) begin
                @(negedge clk_in);
                case (mode)
                    0: pll_locked = 1'b1;
                    1: pll_locked = ($urandom_range(0, 19) != 0);
                    2: pll_locked = 1'b0;
                    default: if ($urandom_range(0, 15) == 0) pll_locked = ~pll_locked;
                endcase
                sw_relock = ($urandom_range(0, 199) == 0);
                reset_n   = ($urandom_range(0, 299) != 0);
            end
        end
        sw_relock = 1'b0;
        reset_n   = 1'b1;
        repeat (5) @(negedge clk_in);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
